mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the `mmio` memory port. It shares the single memory interface between the instruction-fetch requester and the load/store requester. It latches one request at a time, drives the memory strobes for exactly one cycle, waits a fixed read latency, and returns a one-cycle response pulse to the granted requester. A starvation counter keeps fetch from being locked out under back-to-back data traffic.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from the strobe cycle until `mem_rdata` is valid; must be ≥ 1.
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while a fetch request is pending.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_req_addr`  in  32  fetch address.
- `if_rsp_valid`  out  1  fetch data valid (one-cycle pulse).
- `if_rsp_data`  out  32  fetched word.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_req_store`  in  1  1 = store, 0 = load.
- `d_req_access`  in  3  access size/sign code (funct3), passed through.
- `d_req_addr`  in  32  data address.
- `d_req_wdata`  in  32  store data.
- `d_rsp_valid`  out  1  load data valid or store done (one-cycle pulse).
- `d_rsp_data`  out  32  load data; 0 for stores.
- `mem_load`  out  1  to `mmio` `load`.
- `mem_store`  out  1  to `mmio` `store`.
- `mem_access`  out  3  to `mmio` `access`.
- `mem_addr`  out  32  to `mmio` `addr`.
- `mem_wdata`  out  32  to `mmio` `data_in`.
- `mem_rdata`  in  32  from `mmio` `data_out`.

## Operation
- **FSM states:** `IDLE`, `ISSUE`, `WAIT`, `RESP`.
- **IDLE:**
  - Readies are combinational from the valids; at most one ready is high per cycle.
  - On `valid && ready`, latch the command: port id, store bit, access, addr, wdata. Next state is `ISSUE`.
  - A fetch is latched as a load with access `ACC_LW` (3'b010).
- **ISSUE (exactly one cycle):**
  - `mem_load` or `mem_store` is high; `mem_access`, `mem_addr` and `mem_wdata` come from the latched command.
  - A store goes to `RESP`. A load goes to `WAIT` with `lat_cnt` = `MEM_LATENCY` − 1.
- **WAIT:**
  - Decrement `lat_cnt` each cycle.
  - In the cycle where `lat_cnt` = 0, register `mem_rdata` into the response register and go to `RESP`.
  - Strobes are low throughout `WAIT`.
- **RESP (one cycle):**
  - The granted port's `rsp_valid` is high with its registered data; then go to `IDLE`.
  - Both readies are low in `RESP`.
- **Arbitration in IDLE:**
  - Only one valid: grant it.
  - Both valid: grant data, unless `starve_cnt` == `STARVE_LIMIT`, in which case grant fetch.
- **`starve_cnt`:**
  - Increments on each data grant made while `if_req_valid` is high; saturates at `STARVE_LIMIT`.
  - Clears on any fetch grant.
- **Requester rules:** a requester holds valid and payload stable until ready. Requests are never dropped; there are no outstanding multiples.
- **No checking:** no alignment or access-code checking; values pass through unchanged.
- **Unused outputs:** `mem_wdata` is 0 for loads; `mem_addr` and `mem_access` are don't-care outside `ISSUE`, and are driven with the latched values.

## Timing
- **Load:** accept at cycle T; strobe at T+1; `mem_rdata` sampled at T+`MEM_LATENCY`+1; `rsp_valid` at T+`MEM_LATENCY`+2. Next accept is possible at T+`MEM_LATENCY`+3.
- **Store:** accept at T; `mem_store` at T+1; `d_rsp_valid` at T+2.
- **Reset:** `rst` asynchronously forces state `IDLE`, `starve_cnt` = 0, and `lat_cnt` = 0. All outputs go to 0, including the strobes, readies, rsp_valids and rsp_datas.
- **Reset mid-transaction:** the transaction is aborted with no response. The first request after reset deasserts behaves normally.
- **Ready timing:** readies are low while `rst` is high.

## Structure
- **Package `mem_arb_pkg`:**
  - `state_t` enum {`IDLE`, `ISSUE`, `WAIT`, `RESP`}.
  - Access codes `ACC_LB`, `ACC_LH`, `ACC_LW`, `ACC_LBU`, `ACC_LHU`.
  - `port_t` {`PORT_IF`, `PORT_D`}.
- **Sub-module `mem_arb_grant`:** combinational priority/starvation grant logic. It takes the two valids, the idle flag and `starve_cnt`, and produces the two readies.
- **Integration:** `mem_arbiter` instantiates `mem_arb_grant` and connects to `mmio` at the top level.

## Test plan
- **Single fetch:** fetch `if_req_addr` = 0x100 accepted at T, `mem_rdata` = 0x00000013 at T+2. Require `mem_load` high only at T+1 with `mem_access` = 3'b010, and `if_rsp_valid` at T+3 with data 0x00000013.
- **Single store:** store with `d_req_access` = 3'b010, addr 0x200, wdata 0xDEADBEEF. Require `mem_store` high only at T+1 with those values, `mem_load` never high, and `d_rsp_valid` at T+2 with data 0.
- **Simultaneous requests:** fetch and data valid together in `IDLE`. Require `d_req_ready` first, then fetch accepted in the first `IDLE` after the data `RESP`.
- **Starvation:** `STARVE_LIMIT` = 4, data valid continuously, fetch valid continuously. Require exactly 4 data grants, then 1 fetch grant, then data resumes.
- **Latency parameter:** `MEM_LATENCY` = 3 load accepted at T. Require `mem_rdata` sampled at T+4 and `rsp_valid` at T+5.
- **Reset mid-transaction:** `rst` pulsed during `WAIT`. Require all outputs 0 immediately and no `rsp_valid`. A following fetch completes with nominal timing.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  // Sequencer states: accept, strobe memory, wait out read latency, respond.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  // funct3 access codes as understood by mmio.
  localparam logic [2:0] ACC_LB  = 3'b000;
  localparam logic [2:0] ACC_LH  = 3'b001;
  localparam logic [2:0] ACC_LW  = 3'b010;
  localparam logic [2:0] ACC_LBU = 3'b100;
  localparam logic [2:0] ACC_LHU = 3'b101;

  // Command captured at acceptance and replayed onto the memory port.
  typedef struct packed {
    port_t       port;
    logic        store;
    logic [2:0]  access;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant logic: data has priority unless fetch has been
// passed over STARVE_LIMIT times in a row while it was waiting.
module mem_arb_grant #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic          i_if_valid,
  input  logic          i_d_valid,
  input  logic          i_idle,
  input  logic [CW-1:0] i_starve_cnt,
  output logic          o_if_ready,
  output logic          o_d_ready
);

  logic w_starved;

  assign w_starved  = (i_starve_cnt == CW'(STARVE_LIMIT));

  // Exactly one ready can be high: the two terms are mutually exclusive.
  assign o_d_ready  = i_idle && i_d_valid && !(i_if_valid && w_starved);
  assign o_if_ready = i_idle && i_if_valid && (!i_d_valid || w_starved);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mmio port between instruction fetch and load/store.
// One transaction at a time: accept, one-cycle strobe, fixed read
// latency, one-cycle response pulse to the owning requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_store,
  input  logic [2:0]  d_req_access,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        mem_load,
  output logic        mem_store,
  output logic [2:0]  mem_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  state_t        r_state;
  cmd_t          r_cmd;
  logic [LW-1:0] r_lat_cnt;
  logic [CW-1:0] r_starve_cnt;
  logic [31:0]   r_rsp_data;

  logic w_idle;
  logic w_if_grant;
  logic w_d_grant;
  logic w_issue;
  logic w_resp;

  // Readies are suppressed while reset is held, even though state reads IDLE.
  assign w_idle     = (r_state == IDLE) && !rst;
  assign w_if_grant = if_req_valid && if_req_ready;
  assign w_d_grant  = d_req_valid && d_req_ready;
  assign w_issue    = (r_state == ISSUE);
  assign w_resp     = (r_state == RESP);

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) u_grant (
    .i_if_valid   (if_req_valid),
    .i_d_valid    (d_req_valid),
    .i_idle       (w_idle),
    .i_starve_cnt (r_starve_cnt),
    .o_if_ready   (if_req_ready),
    .o_d_ready    (d_req_ready)
  );

  // Sequencer: latch a command, strobe once, count latency, respond once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_lat_cnt  <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_if_grant) begin
            r_cmd.port   <= PORT_IF;
            r_cmd.store  <= 1'b0;
            r_cmd.access <= ACC_LW;
            r_cmd.addr   <= if_req_addr;
            r_cmd.wdata  <= '0;
            r_state      <= ISSUE;
          end else if (w_d_grant) begin
            r_cmd.port   <= PORT_D;
            r_cmd.store  <= d_req_store;
            r_cmd.access <= d_req_access;
            r_cmd.addr   <= d_req_addr;
            r_cmd.wdata  <= d_req_wdata;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cmd.store) begin
            // Stores complete immediately and answer with zero data.
            r_rsp_data <= '0;
            r_state    <= RESP;
          end else begin
            r_lat_cnt  <= LW'(MEM_LATENCY - 1);
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (r_lat_cnt == '0) begin
            r_rsp_data <= mem_rdata;
            r_state    <= RESP;
          end else begin
            r_lat_cnt  <= r_lat_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Starvation counter: data grants that passed over a waiting fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_if_grant) begin
      r_starve_cnt <= '0;
    end else if (w_d_grant && if_req_valid && (r_starve_cnt != CW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign mem_load     = w_issue && !r_cmd.store;
  assign mem_store    = w_issue && r_cmd.store;
  assign mem_access   = r_cmd.access;
  assign mem_addr     = r_cmd.addr;
  assign mem_wdata    = r_cmd.store ? r_cmd.wdata : '0;

  assign if_rsp_valid = w_resp && (r_cmd.port == PORT_IF);
  assign d_rsp_valid  = w_resp && (r_cmd.port == PORT_D);
  assign if_rsp_data  = (r_cmd.port == PORT_IF) ? r_rsp_data : '0;
  assign d_rsp_data   = (r_cmd.port == PORT_D) ? r_rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 and 3) share the request
// inputs; the one not under test is held in reset. Requests are queued,
// held until accepted, and every accept/strobe/response is logged with its
// cycle number, then checked against timing and arbitration rules.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    int          cyc;
    bit          port;   // 0 = fetch, 1 = data
    bit          ld;
    bit          st;
    logic [2:0]  acc;
    logic [31:0] addr;
    logic [31:0] data;
    bit          both;   // both requesters were valid at a grant
    int          cnt;    // model starvation count before a grant
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3;
  bit          sel3;
  logic        if_req_valid, d_req_valid, d_req_store;
  logic [31:0] if_req_addr, d_req_addr, d_req_wdata, mem_rdata;
  logic [2:0]  d_req_access;

  logic        rdy_if [2], rdy_d [2], rv_if [2], rv_d [2], m_ld [2], m_st [2];
  logic [31:0] rd_if [2], rd_d [2], m_addr [2], m_wd [2];
  logic [2:0]  m_acc [2];

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) u_dut1 (
    .clk(clk), .rst(rst1),
    .if_req_valid(if_req_valid), .if_req_ready(rdy_if[0]), .if_req_addr(if_req_addr),
    .if_rsp_valid(rv_if[0]), .if_rsp_data(rd_if[0]),
    .d_req_valid(d_req_valid), .d_req_ready(rdy_d[0]), .d_req_store(d_req_store),
    .d_req_access(d_req_access), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(rv_d[0]), .d_rsp_data(rd_d[0]),
    .mem_load(m_ld[0]), .mem_store(m_st[0]), .mem_access(m_acc[0]),
    .mem_addr(m_addr[0]), .mem_wdata(m_wd[0]), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(LIMIT)) u_dut3 (
    .clk(clk), .rst(rst3),
    .if_req_valid(if_req_valid), .if_req_ready(rdy_if[1]), .if_req_addr(if_req_addr),
    .if_rsp_valid(rv_if[1]), .if_rsp_data(rd_if[1]),
    .d_req_valid(d_req_valid), .d_req_ready(rdy_d[1]), .d_req_store(d_req_store),
    .d_req_access(d_req_access), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(rv_d[1]), .d_rsp_data(rd_d[1]),
    .mem_load(m_ld[1]), .mem_store(m_st[1]), .mem_access(m_acc[1]),
    .mem_addr(m_addr[1]), .mem_wdata(m_wd[1]), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int multi_rdy = 0;
  int mstarve [2] = '{0, 0};
  bit if_got = 0, d_got = 0;

  logic [31:0] if_pend [$];
  ev_t         d_pend [$];
  ev_t         grants [$], strobes [$], rsps [$];

  // Memory read data is a per-cycle signature, so the captured word
  // identifies exactly which cycle the arbiter sampled it in.
  function automatic logic [31:0] rd_val(input int c);
    logic [31:0] u;
    u = c;
    return (u * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  function automatic int lat();
    return sel3 ? 3 : 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // mem_rdata changes mid-cycle; the value seen at the end of cycle c is rd_val(c).
  always @(negedge clk) mem_rdata = rd_val(cyc);

  // Monitor: log accepts, strobes and responses of the selected instance.
  always @(negedge clk) begin
    ev_t e;
    #2;
    if (rst1) mstarve[0] = 0;
    if (rst3) mstarve[1] = 0;
    if (rdy_if[sel3] && rdy_d[sel3]) multi_rdy++;
    if (rdy_if[sel3] && if_req_valid) begin
      e = '{cyc: cyc, port: 1'b0, ld: 1'b1, st: 1'b0, acc: 3'b010, addr: if_req_addr,
            data: 32'd0, both: d_req_valid, cnt: mstarve[sel3]};
      grants.push_back(e);
      mstarve[sel3] = 0;
      if_got = 1;
    end
    if (rdy_d[sel3] && d_req_valid) begin
      e = '{cyc: cyc, port: 1'b1, ld: !d_req_store, st: d_req_store, acc: d_req_access,
            addr: d_req_addr, data: d_req_wdata, both: if_req_valid, cnt: mstarve[sel3]};
      grants.push_back(e);
      if (if_req_valid && mstarve[sel3] < LIMIT) mstarve[sel3]++;
      d_got = 1;
    end
    if (m_ld[sel3] || m_st[sel3]) begin
      e = '{cyc: cyc, port: 1'b0, ld: m_ld[sel3], st: m_st[sel3], acc: m_acc[sel3],
            addr: m_addr[sel3], data: m_wd[sel3], both: 1'b0, cnt: 0};
      strobes.push_back(e);
    end
    if (rv_if[sel3]) begin
      e = '{cyc: cyc, port: 1'b0, ld: 1'b0, st: 1'b0, acc: 3'b0, addr: 32'd0,
            data: rd_if[sel3], both: 1'b0, cnt: 0};
      rsps.push_back(e);
    end
    if (rv_d[sel3]) begin
      e = '{cyc: cyc, port: 1'b1, ld: 1'b0, st: 1'b0, acc: 3'b0, addr: 32'd0,
            data: rd_d[sel3], both: 1'b0, cnt: 0};
      rsps.push_back(e);
    end
  end

  // Requesters: present the head of each queue, hold it until accepted.
  always @(posedge clk) begin
    logic [31:0] a;
    ev_t         d;
    #1;
    if (if_got) begin
      if (if_pend.size() > 0) a = if_pend.pop_front();
      if_got = 0;
    end
    if (d_got) begin
      if (d_pend.size() > 0) d = d_pend.pop_front();
      d_got = 0;
    end
    if_req_valid = (if_pend.size() > 0);
    if (if_pend.size() > 0) if_req_addr = if_pend[0];
    d_req_valid = (d_pend.size() > 0);
    if (d_pend.size() > 0) begin
      d_req_store  = d_pend[0].st;
      d_req_access = d_pend[0].acc;
      d_req_addr   = d_pend[0].addr;
      d_req_wdata  = d_pend[0].data;
    end
  end

  function automatic ev_t mk_data(input bit st, input logic [2:0] acc,
                                  input logic [31:0] addr, input logic [31:0] wd);
    ev_t e;
    e = '{cyc: 0, port: 1'b1, ld: !st, st: st, acc: acc, addr: addr, data: wd, both: 1'b0, cnt: 0};
    return e;
  endfunction

  task automatic clear_logs();
    grants.delete();
    strobes.delete();
    rsps.delete();
  endtask

  task automatic wait_rsps(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rsps.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #3;
    ok = (rsps.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    clear_logs();
    if_pend.push_back(32'h40);
    d_pend.push_back(mk_data(1'b0, 3'b010, 32'h80, 32'h0));
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if ({rdy_if[0], rdy_d[0], rv_if[0], rv_d[0], rd_if[0], rd_d[0], m_ld[0], m_st[0],
         m_acc[0], m_addr[0], m_wd[0]} !== '0)
      begin failures++; $display("FAIL reset_outputs: got nonzero output while rst high, want all 0"); end
    checks++;
    if (grants.size() != 0) begin
      failures++; $display("FAIL reset_ready: got %0d accepts during rst, want 0", grants.size());
    end
    @(negedge clk);
    rst1 = 1'b0;
    wait_rsps(2, 30, ok);
    checks++;
    if (!ok || grants.size() < 2) begin
      failures++; $display("FAIL reset_release: got %0d responses, want 2", rsps.size());
    end else begin
      checks++;
      if (grants[0].port !== 1'b1 || grants[1].port !== 1'b0)
        begin failures++; $display("FAIL reset_first_grant: got ports %0d,%0d want 1,0", grants[0].port, grants[1].port); end
      checks++;
      if (rsps[0].cyc != grants[0].cyc + 3 || rsps[0].data !== rd_val(grants[0].cyc + 2))
        begin failures++; $display("FAIL reset_first_rsp: got cyc %0d data %h want cyc %0d data %h",
                                   rsps[0].cyc, rsps[0].data, grants[0].cyc + 3, rd_val(grants[0].cyc + 2)); end
    end
  endtask

  task automatic test_single_fetch();
    bit ok;
    int t;
    clear_logs();
    if_pend.push_back(32'h100);
    wait_rsps(1, 30, ok);
    checks++;
    if (!ok || grants.size() != 1 || strobes.size() != 1) begin
      failures++; $display("FAIL fetch_counts: got %0d grants %0d strobes %0d rsps, want 1 each",
                           grants.size(), strobes.size(), rsps.size());
    end else begin
      t = grants[0].cyc;
      checks++;
      if (strobes[0].cyc != t + 1 || strobes[0].ld !== 1'b1 || strobes[0].st !== 1'b0)
        begin failures++; $display("FAIL fetch_strobe: got cyc %0d ld %0d st %0d want cyc %0d ld 1 st 0",
                                   strobes[0].cyc, strobes[0].ld, strobes[0].st, t + 1); end
      checks++;
      if (strobes[0].acc !== 3'b010 || strobes[0].addr !== 32'h100)
        begin failures++; $display("FAIL fetch_cmd: got acc %b addr %h want 010 00000100", strobes[0].acc, strobes[0].addr); end
      checks++;
      if (rsps[0].port !== 1'b0 || rsps[0].cyc != t + 3 || rsps[0].data !== rd_val(t + 2))
        begin failures++; $display("FAIL fetch_rsp: got port %0d cyc %0d data %h want port 0 cyc %0d data %h",
                                   rsps[0].port, rsps[0].cyc, rsps[0].data, t + 3, rd_val(t + 2)); end
    end
  endtask

  task automatic test_single_store();
    bit ok;
    int t;
    clear_logs();
    d_pend.push_back(mk_data(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF));
    wait_rsps(1, 30, ok);
    checks++;
    if (!ok || grants.size() != 1 || strobes.size() != 1) begin
      failures++; $display("FAIL store_counts: got %0d grants %0d strobes %0d rsps, want 1 each",
                           grants.size(), strobes.size(), rsps.size());
    end else begin
      t = grants[0].cyc;
      checks++;
      if (strobes[0].cyc != t + 1 || strobes[0].st !== 1'b1 || strobes[0].ld !== 1'b0)
        begin failures++; $display("FAIL store_strobe: got cyc %0d ld %0d st %0d want cyc %0d ld 0 st 1",
                                   strobes[0].cyc, strobes[0].ld, strobes[0].st, t + 1); end
      checks++;
      if (strobes[0].acc !== 3'b010 || strobes[0].addr !== 32'h200 || strobes[0].data !== 32'hDEAD_BEEF)
        begin failures++; $display("FAIL store_cmd: got acc %b addr %h wdata %h want 010 00000200 deadbeef",
                                   strobes[0].acc, strobes[0].addr, strobes[0].data); end
      checks++;
      if (rsps[0].port !== 1'b1 || rsps[0].cyc != t + 2 || rsps[0].data !== 32'd0)
        begin failures++; $display("FAIL store_rsp: got port %0d cyc %0d data %h want port 1 cyc %0d data 0",
                                   rsps[0].port, rsps[0].cyc, rsps[0].data, t + 2); end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    clear_logs();
    if_pend.push_back(32'h500);
    d_pend.push_back(mk_data(1'b0, 3'b100, 32'h600, 32'h0));
    wait_rsps(2, 40, ok);
    checks++;
    if (!ok || grants.size() != 2) begin
      failures++; $display("FAIL simul_counts: got %0d grants %0d rsps, want 2", grants.size(), rsps.size());
    end else begin
      checks++;
      if (grants[0].port !== 1'b1 || grants[1].port !== 1'b0)
        begin failures++; $display("FAIL simul_order: got ports %0d,%0d want 1,0", grants[0].port, grants[1].port); end
      checks++;
      if (grants[1].cyc != rsps[0].cyc + 1)
        begin failures++; $display("FAIL simul_fetch_cyc: got %0d want %0d", grants[1].cyc, rsps[0].cyc + 1); end
    end
  endtask

  task automatic test_starvation();
    bit ok;
    int exp_port [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    @(negedge clk);
    rst1 = 1'b1;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    clear_logs();
    for (int i = 0; i < 10; i++)
      d_pend.push_back(mk_data(1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom));
    if_pend.push_back(32'h1000);
    if_pend.push_back(32'h1004);
    wait_rsps(12, 120, ok);
    checks++;
    if (!ok || grants.size() != 12) begin
      failures++; $display("FAIL starve_counts: got %0d grants %0d rsps, want 12", grants.size(), rsps.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (grants[i].port !== 1'(exp_port[i]))
          begin failures++; $display("FAIL starve_order[%0d]: got port %0d want %0d", i, grants[i].port, exp_port[i]); end
      end
    end
  endtask

  task automatic test_random_traffic(input int n);
    bit ok;
    int pushed, t, k, m, exp_cyc;
    logic [31:0] exp_d;
    clear_logs();
    multi_rdy = 0;
    pushed = 0;
    while (pushed < n) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        if_pend.push_back($urandom);
        pushed++;
      end
      if (pushed < n && $urandom_range(0, 1) == 0) begin
        d_pend.push_back(mk_data(1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom));
        pushed++;
      end
    end
    wait_rsps(n, n * 12 + 40, ok);
    checks++;
    if (!ok || grants.size() != n || strobes.size() != n || rsps.size() != n) begin
      failures++; $display("FAIL rand_counts: got %0d grants %0d strobes %0d rsps, want %0d",
                           grants.size(), strobes.size(), rsps.size(), n);
    end
    checks++;
    if (multi_rdy != 0) begin
      failures++; $display("FAIL rand_one_ready: got %0d cycles with both readies, want 0", multi_rdy);
    end
    m = grants.size();
    if (strobes.size() < m) m = strobes.size();
    if (rsps.size() < m) m = rsps.size();
    for (int i = 0; i < m; i++) begin
      t = grants[i].cyc;
      if (grants[i].both) begin
        k = (grants[i].cnt == LIMIT) ? 0 : 1;
        checks++;
        if (grants[i].port !== 1'(k))
          begin failures++; $display("FAIL rand_arb[%0d]: got port %0d want %0d (starve %0d)", i, grants[i].port, k, grants[i].cnt); end
      end
      checks++;
      if (strobes[i].cyc != t + 1 || strobes[i].ld !== grants[i].ld || strobes[i].st !== grants[i].st ||
          strobes[i].acc !== grants[i].acc || strobes[i].addr !== grants[i].addr ||
          strobes[i].data !== (grants[i].st ? grants[i].data : 32'd0))
        begin failures++; $display("FAIL rand_strobe[%0d]: got cyc %0d ld %0d st %0d acc %b addr %h wd %h want cyc %0d ld %0d st %0d acc %b addr %h",
                                   i, strobes[i].cyc, strobes[i].ld, strobes[i].st, strobes[i].acc, strobes[i].addr,
                                   strobes[i].data, t + 1, grants[i].ld, grants[i].st, grants[i].acc, grants[i].addr); end
      exp_cyc = grants[i].st ? t + 2 : t + lat() + 2;
      exp_d   = grants[i].st ? 32'd0 : rd_val(t + lat() + 1);
      checks++;
      if (rsps[i].cyc != exp_cyc || rsps[i].port !== grants[i].port || rsps[i].data !== exp_d)
        begin failures++; $display("FAIL rand_rsp[%0d]: got cyc %0d port %0d data %h want cyc %0d port %0d data %h",
                                   i, rsps[i].cyc, rsps[i].port, rsps[i].data, exp_cyc, grants[i].port, exp_d); end
    end
  endtask

  task automatic test_latency();
    bit ok;
    int t;
    clear_logs();
    d_pend.push_back(mk_data(1'b0, 3'b100, 32'h300, 32'h0));
    wait_rsps(1, 30, ok);
    checks++;
    if (!ok || grants.size() != 1 || strobes.size() != 1) begin
      failures++; $display("FAIL lat3_counts: got %0d grants %0d strobes %0d rsps, want 1 each",
                           grants.size(), strobes.size(), rsps.size());
    end else begin
      t = grants[0].cyc;
      checks++;
      if (strobes[0].cyc != t + 1 || strobes[0].ld !== 1'b1 || strobes[0].acc !== 3'b100)
        begin failures++; $display("FAIL lat3_strobe: got cyc %0d ld %0d acc %b want cyc %0d ld 1 acc 100",
                                   strobes[0].cyc, strobes[0].ld, strobes[0].acc, t + 1); end
      checks++;
      if (rsps[0].port !== 1'b1 || rsps[0].cyc != t + 5 || rsps[0].data !== rd_val(t + 4))
        begin failures++; $display("FAIL lat3_rsp: got port %0d cyc %0d data %h want port 1 cyc %0d data %h",
                                   rsps[0].port, rsps[0].cyc, rsps[0].data, t + 5, rd_val(t + 4)); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t, k;
    clear_logs();
    d_pend.push_back(mk_data(1'b0, 3'b010, 32'h700, 32'h0));
    if_pend.push_back(32'h800);
    k = 0;
    while (grants.size() < 1 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (grants.size() < 1) begin
      failures++; $display("FAIL rstmid_accept: got no accept within 20 cycles, want 1");
    end else begin
      t = grants[0].cyc;
      while (cyc < t + 2) @(negedge clk);
      rst3 = 1'b1;
      #1;
      checks++;
      if ({rdy_if[1], rdy_d[1], rv_if[1], rv_d[1], rd_if[1], rd_d[1], m_ld[1], m_st[1],
           m_acc[1], m_addr[1], m_wd[1]} !== '0)
        begin failures++; $display("FAIL rstmid_outputs: got nonzero output during rst, want all 0"); end
      repeat (3) @(negedge clk);
      rst3 = 1'b0;
      repeat (6) @(negedge clk);
      wait_rsps(1, 20, ok);
      checks++;
      if (!ok || rsps.size() != 1 || grants.size() != 2) begin
        failures++; $display("FAIL rstmid_counts: got %0d grants %0d rsps, want 2 and 1", grants.size(), rsps.size());
      end else begin
        checks++;
        if (rsps[0].port !== 1'b0 || grants[1].port !== 1'b0 || rsps[0].cyc != grants[1].cyc + 5 ||
            rsps[0].data !== rd_val(grants[1].cyc + 4))
          begin failures++; $display("FAIL rstmid_fetch: got port %0d cyc %0d data %h want port 0 cyc %0d data %h",
                                     rsps[0].port, rsps[0].cyc, rsps[0].data, grants[1].cyc + 5, rd_val(grants[1].cyc + 4)); end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    sel3 = 1'b0;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    d_req_store  = 1'b0;
    d_req_access = 3'b0;
    if_req_addr  = '0;
    d_req_addr   = '0;
    d_req_wdata  = '0;

    test_reset();
    test_single_fetch();
    test_single_store();
    test_simultaneous();
    test_starvation();
    test_random_traffic(40);

    @(negedge clk);
    rst1 = 1'b1;
    sel3 = 1'b1;
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    test_latency();
    test_reset_mid();
    test_random_traffic(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
